// File: rtl/phase_stdp_synapse_pkg.sv
// Shared definitions for the phase-based STDP synapse slice:
// phase/weight widths, default weight bounds and the plasticity outcome.
package phase_stdp_synapse_pkg;

  localparam int unsigned PHASE_W  = 8;
  localparam int unsigned WEIGHT_W = 8;

  localparam logic [WEIGHT_W-1:0] W_MIN_DEF = 8'd1;
  localparam logic [WEIGHT_W-1:0] W_MAX_DEF = 8'd255;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    LTP  = 2'd1,
    LTD  = 2'd2
  } stdp_outcome_e;

endpackage

// File: rtl/phase_stdp_synapse_if.sv
// Signal bundle between the neuron array / gamma oscillator (master)
// and the plastic synapse (slave).
interface phase_stdp_synapse_if;
  import phase_stdp_synapse_pkg::*;

  logic                cycle_start;
  logic [PHASE_W-1:0]  phase_pre;
  logic [PHASE_W-1:0]  phase_post;
  logic                fired_pre;
  logic                fired_post;
  logic [WEIGHT_W-1:0] weight;
  logic                ltp_event;
  logic                ltd_event;

  modport master (
    output cycle_start, phase_pre, phase_post, fired_pre, fired_post,
    input  weight, ltp_event, ltd_event
  );

  modport slave (
    input  cycle_start, phase_pre, phase_post, fired_pre, fired_post,
    output weight, ltp_event, ltd_event
  );
endinterface

// File: rtl/gamma_oscillator.sv
// Gamma-cycle phase counter; cycle_start marks phase 0 of each cycle.
// CYCLE_LEN must not exceed 256 so the phase fits the 8-bit phase width.
module gamma_oscillator
  import phase_stdp_synapse_pkg::*;
#(
  parameter logic [8:0] CYCLE_LEN = 9'd256
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PHASE_W-1:0] phase_out,
  output logic               cycle_start
);

  // Free-running phase counter wrapping at CYCLE_LEN-1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_out <= '0;
    end else if ({1'b0, phase_out} == (CYCLE_LEN - 9'd1)) begin
      phase_out <= '0;
    end else begin
      phase_out <= phase_out + 1'b1;
    end
  end

  assign cycle_start = (phase_out == '0);

endmodule

// File: rtl/phase_stdp_synapse_window_calc.sv
// Combinational STDP window classifier: linear (non-circular) phase
// difference post - pre, classified against a symmetric window.
module stdp_window_calc
  import phase_stdp_synapse_pkg::*;
(
  input  logic [PHASE_W-1:0] phase_pre,
  input  logic [PHASE_W-1:0] phase_post,
  input  logic               fired_pre,
  input  logic               fired_post,
  input  logic [PHASE_W-1:0] window,
  output stdp_outcome_e      outcome
);

  logic signed [PHASE_W:0] delta;
  logic        [PHASE_W:0] mag;

  // Classify the phase difference; Δ=0 and |Δ|>window give no plasticity
  always_comb begin
    delta   = $signed({1'b0, phase_post} - {1'b0, phase_pre});
    mag     = delta[PHASE_W] ? (~delta + 1'b1) : delta;
    outcome = NONE;
    if (fired_pre && fired_post && (delta != '0) && (mag <= {1'b0, window})) begin
      outcome = delta[PHASE_W] ? LTD : LTP;
    end
  end

endmodule

// File: rtl/phase_stdp_synapse.sv
// Single plastic synapse weight updated once per gamma cycle by
// phase-based STDP. Optional simulation assertions are compiled in
// when PHASE_STDP_ASSERT_EN is defined.
module phase_stdp_synapse
  import phase_stdp_synapse_pkg::*;
#(
  parameter logic [WEIGHT_W-1:0] W_INIT  = 8'd128,
  parameter logic [WEIGHT_W-1:0] W_MAX   = W_MAX_DEF,
  parameter logic [WEIGHT_W-1:0] W_MIN   = W_MIN_DEF,
  parameter logic [WEIGHT_W-1:0] ETA_LTP = 8'd4,
  parameter logic [WEIGHT_W-1:0] ETA_LTD = 8'd3,
  parameter logic [PHASE_W-1:0]  WINDOW  = 8'd30
) (
  input  logic                 clk,
  input  logic                 rst_n,
  phase_stdp_synapse_if.slave  bus
);

  stdp_outcome_e       outcome;
  logic [WEIGHT_W-1:0] weight_q;
  logic                ltp_q;
  logic                ltd_q;
  logic [WEIGHT_W:0]   ltp_sum;
  logic [WEIGHT_W:0]   ltd_floor;
  logic [WEIGHT_W-1:0] ltp_next;
  logic [WEIGHT_W-1:0] ltd_next;

  stdp_window_calc u_window (
    .phase_pre  (bus.phase_pre),
    .phase_post (bus.phase_post),
    .fired_pre  (bus.fired_pre),
    .fired_post (bus.fired_post),
    .window     (WINDOW),
    .outcome    (outcome)
  );

  // Saturating candidate weights, computed one bit wider to avoid wrap
  always_comb begin
    ltp_sum   = {1'b0, weight_q} + {1'b0, ETA_LTP};
    ltd_floor = {1'b0, W_MIN} + {1'b0, ETA_LTD};
    ltp_next  = (ltp_sum > {1'b0, W_MAX}) ? W_MAX : ltp_sum[WEIGHT_W-1:0];
    ltd_next  = ({1'b0, weight_q} < ltd_floor) ? W_MIN : (weight_q - ETA_LTD);
  end

  // Weight register and event pulses; reset wins over cycle_start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      weight_q <= W_INIT;
      ltp_q    <= 1'b0;
      ltd_q    <= 1'b0;
    end else begin
      ltp_q <= 1'b0;
      ltd_q <= 1'b0;
      if (bus.cycle_start) begin
        case (outcome)
          LTP: begin
            weight_q <= ltp_next;
            ltp_q    <= 1'b1;
          end
          LTD: begin
            weight_q <= ltd_next;
            ltd_q    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.weight    = weight_q;
  assign bus.ltp_event = ltp_q;
  assign bus.ltd_event = ltd_q;

`ifdef PHASE_STDP_ASSERT_EN
  a_weight_bounds: assert property (@(posedge clk) disable iff (!rst_n)
    $past(rst_n) |-> (weight_q >= W_MIN) && (weight_q <= W_MAX));

  a_events_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(ltp_q && ltd_q));

  a_weight_change_timing: assert property (@(posedge clk) disable iff (!rst_n)
    ($past(rst_n) && !$past(bus.cycle_start)) |-> $stable(weight_q));
`endif

endmodule

// File: tb/tb_phase_stdp_synapse.sv
// Scoreboard bench for phase_stdp_synapse plus a small gamma_oscillator.
module tb_phase_stdp_synapse;

  typedef struct {
    int unsigned w;
    int unsigned ltp;
    int unsigned ltd;
    int unsigned ph;
    int unsigned cs;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] g_phase;
  logic       g_cs;

  phase_stdp_synapse_if bus ();

  phase_stdp_synapse #(
    .W_INIT  (8'd128),
    .W_MAX   (8'd255),
    .W_MIN   (8'd1),
    .ETA_LTP (8'd4),
    .ETA_LTD (8'd3),
    .WINDOW  (8'd30)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  gamma_oscillator #(.CYCLE_LEN(9'd5)) u_osc (
    .clk         (clk),
    .rst_n       (rst_n),
    .phase_out   (g_phase),
    .cycle_start (g_cs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  int   m_w  = 128;
  int   m_ph = 0;

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clock: compare the previous cycle's outputs, then drive new inputs
  task automatic step(input logic rst, input logic cs, input int pre, input int post,
                      input logic fp, input logic fo);
    exp_t e;
    int   d;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("weight", bus.weight, e.w);
      check("ltp_event", bus.ltp_event, e.ltp);
      check("ltd_event", bus.ltd_event, e.ltd);
      check("osc_phase", g_phase, e.ph);
      check("osc_cycle_start", g_cs, e.cs);
    end
    rst_n          = rst;
    bus.cycle_start = cs;
    bus.phase_pre   = pre[7:0];
    bus.phase_post  = post[7:0];
    bus.fired_pre   = fp;
    bus.fired_post  = fo;
    e.ltp = 0;
    e.ltd = 0;
    if (!rst) begin
      m_w  = 128;
      m_ph = 0;
    end else begin
      m_ph = (m_ph + 1) % 5;
      d = post - pre;
      if (cs && fp && fo) begin
        if (d > 0 && d <= 30) begin
          e.ltp = 1;
          m_w = (m_w + 4 > 255) ? 255 : m_w + 4;
        end else if (d < 0 && d >= -30) begin
          e.ltd = 1;
          m_w = (m_w - 3 < 1) ? 1 : m_w - 3;
        end
      end
    end
    e.w  = m_w;
    e.ph = m_ph;
    e.cs = (m_ph == 0) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cycle_start = 1'b0;
    bus.phase_pre   = '0;
    bus.phase_post  = '0;
    bus.fired_pre   = 1'b0;
    bus.fired_post  = 1'b0;

    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5, 20, 1'b1, 1'b1);
    idle();

    step(1'b1, 1'b1, 5, 20, 1'b1, 1'b1);   // 128 -> 132
    idle();
    step(1'b1, 1'b1, 20, 5, 1'b1, 1'b1);   // 132 -> 129
    idle();
    step(1'b1, 1'b1, 10, 10, 1'b1, 1'b1);
    step(1'b1, 1'b1, 10, 10, 1'b1, 1'b1);
    step(1'b1, 1'b1, 0, 50, 1'b1, 1'b1);
    idle();

    // window edges and linear (non-circular) difference
    step(1'b1, 1'b1, 0, 30, 1'b1, 1'b1);
    step(1'b1, 1'b1, 0, 31, 1'b1, 1'b1);
    step(1'b1, 1'b1, 30, 0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 31, 0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 250, 5, 1'b1, 1'b1);
    step(1'b1, 1'b1, 5, 250, 1'b1, 1'b1);
    step(1'b1, 1'b1, 255, 0, 1'b1, 1'b1);

    // inputs without cycle_start, or without both fired flags, do nothing
    step(1'b1, 1'b0, 5, 20, 1'b1, 1'b1);
    step(1'b1, 1'b1, 5, 20, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5, 20, 1'b1, 1'b0);
    step(1'b1, 1'b1, 20, 5, 1'b0, 1'b1);

    for (int unsigned i = 0; i < 64; i++) step(1'b1, 1'b1, 1, 10, 1'b1, 1'b1);
    idle();
    for (int unsigned i = 0; i < 90; i++) step(1'b1, 1'b1, 10, 1, 1'b1, 1'b1);
    idle();

    // mid-run reset, with cycle_start asserted alongside
    step(1'b1, 1'b1, 5, 20, 1'b1, 1'b1);
    step(1'b0, 1'b1, 5, 20, 1'b1, 1'b1);
    step(1'b1, 1'b1, 20, 5, 1'b1, 1'b1);
    for (int unsigned i = 0; i < 6; i++) idle();

    @(negedge clk);
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("weight", bus.weight, e.w);
      check("ltp_event", bus.ltp_event, e.ltp);
      check("ltd_event", bus.ltd_event, e.ltd);
      check("osc_phase", g_phase, e.ph);
      check("osc_cycle_start", g_cs, e.cs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
